// File: rtl/tx_packet_sequencer.sv
// tx_packet_sequencer: sequences one USB TX packet at a time between the command interface, data buffer and TX encoder
module tx_packet_sequencer #(
  parameter int BUF_DEPTH     = 64,
  parameter int START_TIMEOUT = 16,
  parameter int FILL_TIMEOUT  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_type,
  input  logic [6:0] req_len,
  input  logic       toggle_clear,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  output logic [2:0] tx_packet,
  output logic       clear,
  output logic       done,
  output logic [1:0] status,
  output logic       data_toggle
);
  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_ACTIVE, S_FINISH, S_FAIL} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_type, r_status, w_code;
  logic [6:0]      r_len, w_len;
  logic [TW-1:0]   r_timer;
  logic            r_toggle;
  assign w_len       = (req_len > 7'(BUF_DEPTH)) ? 7'(BUF_DEPTH) : req_len;
  assign req_ready   = (r_state == S_IDLE);
  assign tx_packet   = (r_state != S_ISSUE) ? 3'd0 : (r_type == 2'd0) ? 3'd1 + {2'b0, r_toggle} : {1'b0, r_type} + 3'd2;
  assign done        = (r_state == S_FINISH) || (r_state == S_FAIL);
  assign clear       = (r_state == S_FAIL);
  assign status      = r_status;
  assign data_toggle = r_toggle;
  // next-state and failure code selection; error outranks a falling active
  always_comb begin
    w_next = r_state;
    w_code = 2'b00;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = (req_type == 2'd0) ? S_FILL : S_ISSUE;
      S_FILL:   if (buffer_occupancy >= r_len) w_next = S_ISSUE;
                else if (r_timer == TW'(FILL_TIMEOUT - 1)) begin w_next = S_FAIL; w_code = 2'b11; end
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (tx_error) begin w_next = S_FAIL; w_code = 2'b01; end
                else if (tx_transfer_active) w_next = S_ACTIVE;
                else if (r_timer == TW'(START_TIMEOUT - 1)) begin w_next = S_FAIL; w_code = 2'b10; end
      S_ACTIVE: if (tx_error) begin w_next = S_FAIL; w_code = 2'b01; end
                else if (!tx_transfer_active) w_next = S_FINISH;
      default:  w_next = S_IDLE;
    endcase
  end
  // state, per-state timer, latched request, status and data toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_type   <= 2'd0;
      r_len    <= 7'd0;
      r_status <= 2'b00;
      r_toggle <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_timer + 1'b1;
      if (r_state == S_IDLE && req_valid) begin
        r_type <= req_type;
        r_len  <= w_len;
      end
      if (w_next == S_FAIL) r_status <= w_code;
      else if (w_next == S_FINISH) r_status <= 2'b00;
      if (toggle_clear) r_toggle <= 1'b0;
      else if (r_state == S_FINISH && r_type == 2'd0) r_toggle <= ~r_toggle;
    end
  end
endmodule

// File: tb/tb_tx_packet_sequencer.sv
// tb_tx_packet_sequencer: scoreboard bench for tx_packet_sequencer with a scripted encoder/buffer
module tb_tx_packet_sequencer;
  logic       clk = 0, rst = 1;
  logic       req_valid = 0, req_ready;
  logic [1:0] req_type = 0;
  logic [6:0] req_len = 0, buffer_occupancy = 0;
  logic       toggle_clear = 0, tx_transfer_active = 0, tx_error = 0;
  logic [2:0] tx_packet;
  logic       clear, done, data_toggle;
  logic [1:0] status;
  int         n_cmp = 0, n_err = 0;
  logic [2:0] cmd_q[$];
  logic [2:0] res_q[$];
  tx_packet_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_len(req_len), .toggle_clear(toggle_clear), .buffer_occupancy(buffer_occupancy),
    .tx_transfer_active(tx_transfer_active), .tx_error(tx_error), .tx_packet(tx_packet),
    .clear(clear), .done(done), .status(status), .data_toggle(data_toggle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  // scoreboard: every command and every done pulse must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_packet != 3'd0) begin
        if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(tx_packet), 0);
        else chk("cmd", 32'(tx_packet), 32'(cmd_q.pop_front()));
      end
      if (done) begin
        if (res_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("result", 32'({clear, status}), 32'(res_q.pop_front()));
      end else if (clear) chk("clear_without_done", 1, 0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [1:0] t, input logic [6:0] l);
    for (int i = 0; i < 100 && !req_ready; i++) tick();
    req_valid = 1; req_type = t; req_len = l;
    tick();
    req_valid = 0;
  endtask
  task automatic wait_cmd(input int exp_lat);
    int lat = 1;
    while (tx_packet == 3'd0 && lat < 3000) begin tick(); lat++; end
    if (tx_packet == 3'd0) chk("cmd_timeout", 0, 1);
    else if (exp_lat > 0) chk("cmd_latency", 32'(lat), 32'(exp_lat));
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 3000) begin tick(); lat++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic activity(input int dly, input int len);
    repeat (dly) tick();
    tx_transfer_active = 1;
    repeat (len) tick();
    tx_transfer_active = 0;
  endtask
  task automatic pkt_ok(input logic [1:0] t, input logic [6:0] l, input logic [2:0] cmd, input int lat);
    int dl;
    cmd_q.push_back(cmd); res_q.push_back(3'b000);
    accept(t, l);
    wait_cmd(lat);
    activity(3, 20);
    wait_done(dl);
    tick();
  endtask
  initial begin
    int dl;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_pkt", 32'(tx_packet), 0);
    chk("rst_done_clear", 32'({done, clear}), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_toggle", 32'(data_toggle), 0);
    rst = 0;
    tick();
    buffer_occupancy = 8;
    pkt_ok(2'd0, 7'd8, 3'd1, 2);
    chk("toggle_after_data0", 32'(data_toggle), 1);
    pkt_ok(2'd0, 7'd8, 3'd2, 2);
    chk("toggle_after_data1", 32'(data_toggle), 0);
    pkt_ok(2'd1, 7'd0, 3'd3, 1);
    chk("toggle_after_ack", 32'(data_toggle), 0);
    cmd_q.push_back(3'd1); res_q.push_back(3'b000);
    accept(2'd0, 7'd8);
    wait_cmd(2);
    activity(2, 5);
    tick();
    toggle_clear = 1;
    wait_done(dl);
    tick();
    toggle_clear = 0;
    chk("toggle_clear_beats_flip", 32'(data_toggle), 0);
    buffer_occupancy = 0;
    cmd_q.push_back(3'd1); res_q.push_back(3'b000);
    accept(2'd0, 7'd16);
    for (int i = 0; i < 40; i++) begin
      buffer_occupancy = 7'(i * 16 / 39);
      chk("fill_hold", 32'(tx_packet), 0);
      tick();
    end
    wait_cmd(0);
    activity(1, 4);
    wait_done(dl);
    tick();
    chk("toggle_after_fill", 32'(data_toggle), 1);
    buffer_occupancy = 15;
    res_q.push_back(3'b111);
    accept(2'd0, 7'd16);
    wait_done(dl);
    chk("fill_timeout_lat", 32'(dl + 1), 1025);
    tick();
    chk("toggle_after_fill_to", 32'(data_toggle), 1);
    cmd_q.push_back(3'd2); res_q.push_back(3'b110);
    accept(2'd0, 7'd0);
    wait_cmd(2);
    wait_done(dl);
    chk("start_timeout_lat", 32'(dl), 17);
    tick();
    chk("toggle_after_start_to", 32'(data_toggle), 1);
    cmd_q.push_back(3'd5); res_q.push_back(3'b101);
    accept(2'd3, 7'd0);
    wait_cmd(1);
    activity(2, 5);
    tx_transfer_active = 1; tx_error = 1;
    tick();
    tx_transfer_active = 0; tx_error = 0;
    wait_done(dl);
    tick();
    cmd_q.push_back(3'd4); res_q.push_back(3'b101);
    accept(2'd2, 7'd0);
    wait_cmd(1);
    activity(2, 5);
    tx_error = 1;
    tick();
    tx_error = 0;
    wait_done(dl);
    tick();
    chk("toggle_after_errors", 32'(data_toggle), 1);
    buffer_occupancy = 8;
    cmd_q.push_back(3'd2);
    accept(2'd0, 7'd8);
    wait_cmd(2);
    tick();
    tx_transfer_active = 1;
    repeat (4) tick();
    #2 rst = 1;
    #1;
    chk("async_rst_ready", 32'(req_ready), 1);
    chk("async_rst_outs", 32'({tx_packet, done, clear, status}), 0);
    chk("async_rst_toggle", 32'(data_toggle), 0);
    tick();
    rst = 0; tx_transfer_active = 0;
    repeat (3) tick();
    chk("post_rst_ready", 32'(req_ready), 1);
    buffer_occupancy = 64;
    pkt_ok(2'd0, 7'd100, 3'd1, 2);
    chk("toggle_after_clamp", 32'(data_toggle), 1);
    chk("cmd_q_empty", 32'(cmd_q.size()), 0);
    chk("res_q_empty", 32'(res_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
